// File: rtl/spi_accel_responder.sv
`default_nettype none
// ============================================================================
//  Module   : spi_accel_responder
//  Brief    : SPI mode-0 slave modelling an accelerometer. Decodes 0x0A write
//             and 0x0B read framing and serves a 64-byte register file. All
//             SPI pins are oversampled in the clk domain.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_accel_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  DEVID       = 8'hAD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    input  logic [7:0] xdata,
    output logic       miso,
    output logic       miso_oe,
    output logic [7:0] power_ctl,
    output logic       measuring,
    output logic       wr_pulse,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR_W = 3'd2,
        ST_ADDR_R = 3'd3,
        ST_WDATA  = 3'd4,
        ST_RDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

    localparam logic [7:0] CMD_WRITE     = 8'h0A;
    localparam logic [7:0] CMD_READ      = 8'h0B;
    localparam logic [7:0] ADDR_SOFT_RST = 8'h1F;
    localparam logic [7:0] SOFT_RST_KEY  = 8'h52;
    localparam logic [5:0] IDX_POWER_CTL = 6'h2D;

    // Synchronizers and edge history
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;

    // Protocol state
    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  rx_q, rx_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  addr_q, addr_d;
    logic        miso_q, miso_d;
    logic        wr_pulse_q, wr_pulse_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [7:0]  regs_q [64];
    logic [7:0]  regs_d [64];

    logic        sclk_s, cs_s, mosi_s;
    logic        sclk_rise, sclk_fall;
    logic [7:0]  rx_byte;
    logic [7:0]  rd_addr, rd_data;
    logic        wr_ok;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign rx_byte   = {rx_q, mosi_s};

    // Writes to address 0, the live-sample slot and the unmapped upper range are dropped
    assign wr_ok = (addr_q < 8'h40) && (addr_q != 8'h00) && (addr_q != 8'h08);

    // Register-file read port; the ADDR_R load reads at the address byte just received
    always_comb begin
        rd_addr = (state_q == ST_ADDR_R) ? rx_byte : addr_q;
        if (rd_addr == 8'h00)
            rd_data = DEVID;
        else if (rd_addr == 8'h08)
            rd_data = xdata;
        else if (rd_addr < 8'h40)
            rd_data = regs_q[rd_addr[5:0]];
        else
            rd_data = 8'h00;
    end

    // Next-state logic for synchronizers, framing FSM, shifters and register file
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_d = sclk_s;

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        addr_d     = addr_q;
        miso_d     = miso_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        regs_d     = regs_q;

        if (cs_s) begin
            // Deselect wins over any coincident SCLK edge; partial bytes are lost
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
        end else if (state_q == ST_IDLE) begin
            state_d   = ST_CMD;
            bit_cnt_d = 3'd0;
        end else if (sclk_rise) begin
            rx_d      = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                case (state_q)
                    ST_CMD: begin
                        if (rx_byte == CMD_WRITE)
                            state_d = ST_ADDR_W;
                        else if (rx_byte == CMD_READ)
                            state_d = ST_ADDR_R;
                        else
                            state_d = ST_IGNORE;
                    end
                    ST_ADDR_W: begin
                        addr_d  = rx_byte;
                        state_d = ST_WDATA;
                    end
                    ST_ADDR_R: begin
                        tx_d    = rd_data;
                        addr_d  = rx_byte + 8'd1;
                        state_d = ST_RDATA;
                    end
                    ST_WDATA: begin
                        addr_d = addr_q + 8'd1;
                        if (wr_ok) begin
                            wr_pulse_d = 1'b1;
                            wr_addr_d  = addr_q;
                            wr_data_d  = rx_byte;
                            if (addr_q == ADDR_SOFT_RST && rx_byte == SOFT_RST_KEY) begin
                                for (int i = 0; i < 64; i++)
                                    regs_d[i] = 8'h00;
                            end else begin
                                regs_d[addr_q[5:0]] = rx_byte;
                            end
                        end
                    end
                    ST_RDATA: begin
                        tx_d   = rd_data;
                        addr_d = addr_q + 8'd1;
                    end
                    default: ;
                endcase
            end
        end else if (sclk_fall && state_q == ST_RDATA) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
        end

        if (state_d != ST_RDATA)
            miso_d = 1'b0;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 7'd0;
            tx_q        <= 8'h00;
            addr_q      <= 8'h00;
            miso_q      <= 1'b0;
            wr_pulse_q  <= 1'b0;
            wr_addr_q   <= 8'h00;
            wr_data_q   <= 8'h00;
            for (int i = 0; i < 64; i++)
                regs_q[i] <= 8'h00;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            miso_q      <= miso_d;
            wr_pulse_q  <= wr_pulse_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            regs_q      <= regs_d;
        end
    end

    assign miso      = miso_q;
    assign miso_oe   = ~cs_s;
    assign power_ctl = regs_q[IDX_POWER_CTL];
    assign measuring = (power_ctl[1:0] == 2'b10);
    assign wr_pulse  = wr_pulse_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_accel_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_accel_responder
//  Brief    : Self-checking bench: an SPI mode-0 master drives byte-level
//             transactions, a byte-level register model predicts MISO bytes,
//             committed writes and power_ctl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_accel_responder;

    localparam int         HALF  = 10;
    localparam logic [7:0] DEVID = 8'hAD;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic [7:0] xdata;
    logic       miso;
    logic       miso_oe;
    logic [7:0] power_ctl;
    logic       measuring;
    logic       wr_pulse;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    spi_accel_responder #(.SYNC_STAGES(2), .DEVID(DEVID)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .xdata(xdata), .miso(miso), .miso_oe(miso_oe), .power_ctl(power_ctl),
        .measuring(measuring), .wr_pulse(wr_pulse), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  tx_bytes [0:15];
    logic [7:0]  rx0      [0:15];
    logic [7:0]  rx1      [0:15];
    logic [7:0]  exp_rx   [0:15];
    logic [7:0]  mem      [0:63];
    logic [15:0] exp_wr [$];
    logic [15:0] got_wr [$];
    logic        prev_pulse = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle observation: log commits and check output invariants
    always @(negedge clk) begin
        if (rst) begin
            prev_pulse = 1'b0;
        end else begin
            if (wr_pulse) got_wr.push_back({wr_addr, wr_data});
            chk("measuring_vs_power_ctl", {31'd0, measuring}, {31'd0, power_ctl[1:0] == 2'b10});
            chk("miso_idle_zero", {31'd0, (!busy) && miso}, 32'd0);
            chk("wr_pulse_single", {31'd0, wr_pulse && prev_pulse}, 32'd0);
            prev_pulse = wr_pulse;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    function automatic logic [7:0] model_read(input logic [7:0] a);
        if (a == 8'h00) return DEVID;
        if (a == 8'h08) return xdata;
        if (a < 8'h40) return mem[a[5:0]];
        return 8'h00;
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [7:0] d);
        if (a == 8'h1F && d == 8'h52) begin
            for (int i = 0; i < 64; i++) mem[i] = 8'h00;
            exp_wr.push_back({a, d});
        end else if (a != 8'h00 && a != 8'h08 && a < 8'h40) begin
            mem[a[5:0]] = d;
            exp_wr.push_back({a, d});
        end
    endtask

    task automatic model_txn(input int n);
        logic [7:0] ptr;
        exp_wr.delete();
        got_wr.delete();
        for (int i = 0; i < 16; i++) exp_rx[i] = 8'h00;
        if (n >= 2 && tx_bytes[0] == 8'h0A) begin
            ptr = tx_bytes[1];
            for (int i = 2; i < n; i++) begin
                model_write(ptr, tx_bytes[i]);
                ptr = ptr + 8'd1;
            end
        end else if (n >= 2 && tx_bytes[0] == 8'h0B) begin
            ptr = tx_bytes[1];
            for (int i = 2; i < n; i++) begin
                exp_rx[i] = model_read(ptr);
                ptr = ptr + 8'd1;
            end
        end
    endtask

    // ---------------- SPI master ----------------
    task automatic spi_run(input int n, input int extra);
        int nb;
        @(negedge clk);
        cs_n = 1'b0;
        mosi = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int b = 0; b < n + ((extra > 0) ? 1 : 0); b++) begin
            nb = (b < n) ? 8 : extra;
            rx0[b] = 8'h00;
            rx1[b] = 8'h00;
            for (int k = 0; k < nb; k++) begin
                mosi = tx_bytes[b][7-k];
                repeat (HALF) @(negedge clk);
                sclk = 1'b1;
                rx0[b][7-k] = miso;
                repeat (HALF - 1) @(negedge clk);
                rx1[b][7-k] = miso;
                @(negedge clk);
                sclk = 1'b0;
            end
        end
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic run_txn(input int n, input int extra);
        model_txn(n);
        spi_run(n, extra);
        for (int b = 0; b < n; b++) begin
            chk("miso_byte_at_rise", {24'd0, rx0[b]}, {24'd0, exp_rx[b]});
            chk("miso_byte_before_fall", {24'd0, rx1[b]}, {24'd0, exp_rx[b]});
        end
        chk("wr_count", got_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            chk("wr_entry", {16'd0, got_wr[i]}, {16'd0, exp_wr[i]});
        if (exp_wr.size() > 0)
            chk("wr_addr_data_hold", {16'd0, wr_addr, wr_data}, {16'd0, exp_wr[exp_wr.size()-1]});
        chk("power_ctl_model", {24'd0, power_ctl}, {24'd0, mem[6'h2D]});
    endtask

    task automatic set3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        tx_bytes[0] = a; tx_bytes[1] = b; tx_bytes[2] = c;
    endtask

    initial begin
        logic [7:0] cmd, adr;
        int n, extra, r;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        for (int i = 0; i < 16; i++) tx_bytes[i] = 8'h00;
        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; xdata = 8'h00;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_miso", {31'd0, miso}, 32'd0);
        chk("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        chk("rst_power_ctl", {24'd0, power_ctl}, 32'h00);
        chk("rst_measuring", {31'd0, measuring}, 32'd0);
        chk("rst_wr_pulse", {31'd0, wr_pulse}, 32'd0);
        chk("rst_wr_addr", {24'd0, wr_addr}, 32'h00);
        chk("rst_wr_data", {24'd0, wr_data}, 32'h00);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Device ID read
        set3(8'h0B, 8'h00, 8'h00);
        run_txn(3, 0);
        chk("devid_literal", {24'd0, rx0[2]}, 32'hAD);

        // Measurement mode
        set3(8'h0A, 8'h2D, 8'h02);
        run_txn(3, 0);
        chk("meas_power_ctl", {24'd0, power_ctl}, 32'h02);
        chk("meas_measuring", {31'd0, measuring}, 32'd1);
        chk("meas_wr_count", got_wr.size(), 32'd1);
        chk("meas_wr_entry", {16'd0, (got_wr.size() > 0) ? got_wr[0] : 16'h0000}, 32'h2D02);

        // Live sample read
        xdata = 8'h5A;
        set3(8'h0B, 8'h08, 8'h00); tx_bytes[3] = 8'h00;
        run_txn(4, 0);
        chk("xdata_literal", {24'd0, rx0[2]}, 32'h5A);
        chk("reg09_literal", {24'd0, rx0[3]}, 32'h00);

        // Burst crossing the top of the register file
        set3(8'h0A, 8'h3E, 8'h11); tx_bytes[3] = 8'h22; tx_bytes[4] = 8'h33;
        run_txn(5, 0);
        chk("burst_wr_count", got_wr.size(), 32'd2);
        set3(8'h0B, 8'h3E, 8'h00); tx_bytes[3] = 8'h00; tx_bytes[4] = 8'h00;
        run_txn(5, 0);
        chk("burst_rb_3e", {24'd0, rx0[2]}, 32'h11);
        chk("burst_rb_3f", {24'd0, rx0[3]}, 32'h22);
        chk("burst_rb_40", {24'd0, rx0[4]}, 32'h00);

        // Abort mid data byte
        set3(8'h0A, 8'h2D, 8'h06);
        run_txn(2, 4);
        chk("abort_power_ctl", {24'd0, power_ctl}, 32'h02);
        chk("abort_no_write", got_wr.size(), 32'd0);

        // Illegal command
        set3(8'h0C, 8'h2D, 8'h06);
        run_txn(3, 0);
        chk("illegal_no_write", got_wr.size(), 32'd0);
        chk("illegal_power_ctl", {24'd0, power_ctl}, 32'h02);

        // cs_n glitch with no SCLK, then a fresh read
        @(negedge clk); cs_n = 1'b0;
        repeat (4) @(negedge clk); cs_n = 1'b1;
        repeat (4) @(negedge clk);
        set3(8'h0B, 8'h2D, 8'h00);
        run_txn(3, 0);
        chk("after_glitch_read", {24'd0, rx0[2]}, 32'h02);

        // Pointer wrap from 0xFF to 0x00
        set3(8'h0B, 8'hFF, 8'h00); tx_bytes[3] = 8'h00;
        run_txn(4, 0);
        chk("wrap_ff", {24'd0, rx0[2]}, 32'h00);
        chk("wrap_00", {24'd0, rx0[3]}, 32'hAD);

        // Soft reset
        set3(8'h0A, 8'h1F, 8'h52);
        run_txn(3, 0);
        chk("soft_power_ctl", {24'd0, power_ctl}, 32'h00);
        chk("soft_measuring", {31'd0, measuring}, 32'd0);
        chk("soft_wr_addr", {24'd0, wr_addr}, 32'h1F);
        chk("soft_wr_data", {24'd0, wr_data}, 32'h52);
        set3(8'h0B, 8'h3E, 8'h00);
        run_txn(3, 0);
        chk("soft_rb_3e", {24'd0, rx0[2]}, 32'h00);
        set3(8'h0B, 8'h1F, 8'h00);
        run_txn(3, 0);
        chk("soft_rb_1f", {24'd0, rx0[2]}, 32'h00);

        // rst in the middle of a transaction
        set3(8'h0A, 8'h2D, 8'h02);
        run_txn(3, 0);
        @(negedge clk); cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            mosi = 1'b1;
            repeat (HALF) @(negedge clk); sclk = 1'b1;
            repeat (HALF) @(negedge clk); sclk = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_power_ctl", {24'd0, power_ctl}, 32'h00);
        chk("midrst_measuring", {31'd0, measuring}, 32'd0);
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        @(negedge clk); cs_n = 1'b1; mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        set3(8'h0A, 8'h2D, 8'h02);
        run_txn(3, 0);
        chk("after_rst_power_ctl", {24'd0, power_ctl}, 32'h02);

        // Randomized traffic
        for (int t = 0; t < 30; t++) begin
            xdata = 8'($urandom);
            r = $urandom_range(0, 9);
            cmd = (r < 4) ? 8'h0A : (r < 8) ? 8'h0B : 8'($urandom);
            r = $urandom_range(0, 9);
            if (r < 7)      adr = 8'($urandom_range(0, 8'h45));
            else if (r < 8) adr = 8'($urandom_range(8'hFC, 8'hFF));
            else            adr = 8'($urandom);
            tx_bytes[0] = cmd;
            tx_bytes[1] = adr;
            for (int i = 2; i < 8; i++) tx_bytes[i] = 8'($urandom);
            n = $urandom_range(1, 6);
            extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            run_txn(n, extra);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_accel_responder.md
# spi_accel_responder

SPI mode-0 slave modelling the accelerometer end of the sensor link: it decodes the write (0x0A) and read (0x0B) command framing issued by the team's SPI master and serves a 64-byte register file. All SPI pins are oversampled in the system clock domain (100 MHz against a 5 MHz SCLK), so the block runs on one clock. It is the bench partner for the master and a standalone sensor model for system simulation.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth on sclk, cs_n and mosi (allowed range 2 to 3).
- DEVID, 8'hAD: read-only value at address 0x00.

Ports:
- clk input 1: system clock; must run at least 8× SCLK.
- rst input 1: reset rst, asynchronous, active-high; clock clk.
- sclk input 1: SPI clock from the master, idle low.
- cs_n input 1: chip select, active low.
- mosi input 1: master data, MSB first.
- xdata input 8: live sensor sample, read-only at address 0x08.
- miso output 1: slave data, MSB first.
- miso_oe output 1: high while a transaction is active (synced cs_n low).
- power_ctl output 8: mirror of register 0x2D.
- measuring output 1: high when power_ctl[1:0] == 2'b10.
- wr_pulse output 1: one-clk pulse for each committed register write.
- wr_addr output 8: address of the last committed write.
- wr_data output 8: data of the last committed write.
- busy output 1: state is anything other than IDLE.

## Operation
- sclk, cs_n and mosi each pass through SYNC_STAGES flops. Rising and falling SCLK events come from the synced sclk against its previous value. Edges are honoured only while synced cs_n is low.
- Bit counter is 3 bits. It clears on a cs_n falling edge. Each rising event shifts synced mosi into rx_shift. The 8th rising event completes a byte.
- States:
  - IDLE: cs_n high. Goes to CMD on cs_n low.
  - CMD: byte 0x0A goes to ADDR_W, 0x0B goes to ADDR_R, any other value goes to IGNORE.
  - ADDR_W, ADDR_R: the completed byte loads the 8-bit addr pointer. Next state is WDATA or RDATA respectively.
  - WDATA: each completed byte commits to reg[addr]; addr then increments.
  - RDATA: streams data bytes out; see below.
  - IGNORE: sinks bits with miso held 0 until cs_n rises.
- Any state returns to IDLE when synced cs_n goes high. A partial byte is discarded and never committed.
- Register map:
  - 0x00 reads DEVID and is read-only.
  - 0x08 reads xdata and is read-only.
  - Addresses 0x01–0x3F other than 0x08 are read/write; their reset value is 0x00.
  - Addresses 0x40–0xFF read as 0x00; writes to them are dropped.
- Commit rules:
  - A dropped write or read-only write produces no wr_pulse.
  - An accepted write sets wr_pulse, wr_addr and wr_data.
  - Writing 0x52 to 0x1F is a soft reset. It restores every register to its reset value, including 0x2D, so measuring goes to 0. wr_pulse still fires with addr 0x1F and data 0x52. Register 0x1F itself reads back 0x00 afterwards.
- The addr pointer increments mod 256, so 0xFF wraps to 0x00.
- Read path:
  - The 8th rising event of ADDR_R, and of every RDATA byte, loads tx_shift with the value at the current pointer and then increments the pointer. For the ADDR_R load this is the address byte just received.
  - On each falling event while active: miso <= tx_shift[7], then tx_shift shifts left by one bit.
  - Result: the MSB appears on the falling edge that follows the last address bit, which is valid before the master's next rising edge (mode 0).
  - xdata is captured at tx_shift load time, not per bit.
- miso is 0 whenever the state is not RDATA.

## Timing
- Reset values:
  - Outputs: miso 0, miso_oe 0, power_ctl 0x00, measuring 0, wr_pulse 0, wr_addr 0x00, wr_data 0x00, busy 0.
  - Internal: state IDLE and all registers at their reset values.
- miso updates SYNC_STAGES+1 clk cycles after the pin-level SCLK falling edge. That is 30 ns at SYNC_STAGES=2, inside the 100 ns half-period.
- A write commits, and wr_pulse rises, one clk after the synced 8th rising event. power_ctl and measuring update in that same cycle.
- When cs_n rising and an sclk rising event are seen in the same clk sample, cs_n wins and the edge is ignored.
- A cs_n low→high→low sequence with no SCLK between starts a fresh CMD with the bit counter at 0.
- rst mid-transaction aborts immediately and forces all reset values. Traffic resumes cleanly at the next cs_n falling edge.

## Test plan
- Reset and ID: assert rst, then read 0x0B 0x00 plus 1 dummy byte → all outputs at reset values; miso byte 0xAD.
- Measurement mode: send 0x0A 0x2D 0x02 → power_ctl 0x02, measuring 1, exactly one wr_pulse with wr_addr 0x2D and wr_data 0x02.
- Sample read: set xdata=0x5A, send 0x0B 0x08 plus 2 dummy bytes → miso 0x5A then 0x00 (register 0x09), MSB first, each bit stable across SCLK rising edges.
- Burst with boundary: send 0x0A 0x3E 0x11 0x22 0x33 → 0x3E=0x11, 0x3F=0x22, the 0x40 write dropped, two wr_pulses; read-back confirms.
- Abort and illegal command: cs_n high after 4 bits of a 0x2D data byte → power_ctl unchanged, no wr_pulse. Command 0x0C 0x2D 0x06 → miso stays 0, no writes. Next valid transaction works.
- Soft reset: after measuring=1, send 0x0A 0x1F 0x52 → power_ctl 0x00, measuring 0, reg 0x3E reads back 0x00.
